id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
ID/EX pipeline register of the five-stage core. Sits directly downstream of the hazard detection unit: it consumes Stall and inserts a bubble into EX on a load-use hazard. It also returns the EX-stage destination number and memory-read flag to the HDU as Old_Dst_NUM/DMR. It carries stall/flush bookkeeping: a saturating stall-cycle counter and a consecutive-stall watchdog.

Parameters:
DATA_W, 16, width of data/immediate/PC fields
ALU_OP_W, 5, width of ALU opcode; opcode 0 = NOP
CNT_W, 16, width of stall_count
MAX_STALL, 4, consecutive stall cycles allowed before stall_timeout sets
NO_REG, 4'hF, destination number used for bubbles (register map: R0-R7 = 0-7, PC = 8, SP = 9)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
enable  in  1  global pipeline enable; 0 = hold all state
stall  in  1  from HDU Stall; 1 = insert bubble into EX
flush  in  1  from branch resolution; 1 = squash ID contents
id_valid  in  1  ID holds a real instruction
id_src1_num, id_src2_num, id_dst_num  in  4 each  register numbers
id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
id_alu_op  in  ALU_OP_W  ALU opcode
id_src1_data, id_src2_data, id_imm, id_pc  in  DATA_W each  operands/PC
ex_valid  out  1  registered valid
ex_src1_num, ex_src2_num, ex_dst_num  out  4 each  registered numbers
ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls
ex_alu_op  out  ALU_OP_W  registered opcode
ex_src1_data, ex_src2_data, ex_imm, ex_pc  out  DATA_W each  registered operands
hdu_old_dst_num  out  4  = ex_dst_num (to HDU Old_Dst_NUM)
hdu_dmr  out  1  = ex_valid & ex_mem_read (to HDU DMR)
ifid_hold  out  1  = enable & stall & ~flush (freezes PC and IF/ID)
stall_count  out  CNT_W  total bubble cycles inserted, saturating
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Single clock domain, all updates on rising clk. Reset is synchronous and active-high.
- Priority per edge: rst > flush > ~enable > stall > id_valid.
- rst: load a bubble. Bubble = ex_valid 0; reg_write/mem_read/mem_write 0; alu_op 0; all src/dst nums NO_REG; data fields 0. Also clear stall_count, the consecutive counter and stall_timeout.
- flush (rst=0): load a bubble regardless of enable/stall. Consecutive counter clears. stall_count unchanged.
- ~enable: every register holds, counters included. ifid_hold = 0.
- stall (enable=1, flush=0): load a bubble and increment stall_count, saturating at all-ones. Increment the consecutive counter, saturating at MAX_STALL+1.
- When the consecutive counter would exceed MAX_STALL, set stall_timeout. It stays set until rst.
- Normal (enable=1, stall=0, flush=0):
  - id_valid=1: capture all id_* into ex_*, ex_valid 1.
  - id_valid=0: load a bubble.
  - In both cases the consecutive counter clears.
- Latency: one cycle from ID input to ex_* output.
- hdu_old_dst_num, hdu_dmr and ifid_hold are combinational from the registers/inputs listed; there is no extra delay.
- Bubbles never carry mem_read, so a bubble after a stall always breaks the HDU loop. Stall cannot self-sustain on the same instruction for more than one cycle.
- flush and stall in the same cycle: the flush behaviour applies and ifid_hold = 0.

Test Plan:
- rst=1 for 2 edges with random id_* → ex_valid=0, ex_dst_num=4'hF, hdu_dmr=0, stall_count=0, stall_timeout=0.
- enable=1, id_valid=1, id_dst_num=3, id_mem_read=1, id_src1_data=16'h1234 → next edge: ex_dst_num=3, ex_src1_data=16'h1234, hdu_old_dst_num=3, hdu_dmr=1.
- Load-use: after the above, stall=1 for one edge → ex_valid=0, ex_mem_read=0, hdu_dmr=0, ifid_hold=1 during the stall cycle, stall_count=1. Next edge with stall=0 captures the held ID instruction (id_src1_num=3).
- stall=1 and flush=1 together → bubble, ifid_hold=0, stall_count unchanged; id_dst_num=5 with flush alone → ex_dst_num=4'hF.
- enable=0 for 3 edges while id_* change and stall=1 → all ex_* and stall_count unchanged, ifid_hold=0.
- MAX_STALL=4: stall=1 for 5 consecutive edges → stall_timeout=1 after the 5th edge, stall_count=5. After deassert, stall_timeout stays 1 until rst.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion and stall bookkeeping
module id_ex_stage_reg #(
  parameter int DATA_W = 16,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W = 16,
  parameter int MAX_STALL = 4,
  parameter logic [3:0] NO_REG = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [3:0]          id_src1_num,
  input  logic [3:0]          id_src2_num,
  input  logic [3:0]          id_dst_num,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]   id_src1_data,
  input  logic [DATA_W-1:0]   id_src2_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [DATA_W-1:0]   id_pc,
  output logic                ex_valid,
  output logic [3:0]          ex_src1_num,
  output logic [3:0]          ex_src2_num,
  output logic [3:0]          ex_dst_num,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]   ex_src1_data,
  output logic [DATA_W-1:0]   ex_src2_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_pc,
  output logic [3:0]          hdu_old_dst_num,
  output logic                hdu_dmr,
  output logic                ifid_hold,
  output logic [CNT_W-1:0]    stall_count,
  output logic                stall_timeout
);
  localparam int CONS_W = $clog2(MAX_STALL + 2);
  logic [CONS_W-1:0] cons;
  logic              bubble;
  assign bubble = rst | flush | (enable & (stall | ~id_valid));
  assign hdu_old_dst_num = ex_dst_num;
  assign hdu_dmr = ex_valid & ex_mem_read;
  assign ifid_hold = enable & stall & ~flush;
  // Pipeline register: bubble has priority, otherwise capture ID when enabled, else hold
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid     <= 1'b0;
      ex_src1_num  <= NO_REG;
      ex_src2_num  <= NO_REG;
      ex_dst_num   <= NO_REG;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_op    <= '0;
      ex_src1_data <= '0;
      ex_src2_data <= '0;
      ex_imm       <= '0;
      ex_pc        <= '0;
    end else if (enable) begin
      ex_valid     <= 1'b1;
      ex_src1_num  <= id_src1_num;
      ex_src2_num  <= id_src2_num;
      ex_dst_num   <= id_dst_num;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_alu_op    <= id_alu_op;
      ex_src1_data <= id_src1_data;
      ex_src2_data <= id_src2_data;
      ex_imm       <= id_imm;
      ex_pc        <= id_pc;
    end
  end
  // Stall accounting: saturating totals, consecutive-stall run length and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count   <= '0;
      cons          <= '0;
      stall_timeout <= 1'b0;
    end else if (flush) begin
      cons <= '0;
    end else if (enable) begin
      if (stall) begin
        stall_count <= (&stall_count) ? stall_count : stall_count + 1'b1;
        cons        <= (cons == CONS_W'(MAX_STALL + 1)) ? cons : cons + 1'b1;
        if (cons >= CONS_W'(MAX_STALL)) stall_timeout <= 1'b1;
      end else begin
        cons <= '0;
      end
    end
  end
endmodule
